pipelined_adder: RTL and testbench

Parametrised, pipelined successor to the 4-bit ripple adder. It adds or subtracts two WIDTH-bit operands, splitting the carry chain into STAGES equal slices with one register stage per slice. A valid/ready handshake on both sides carries back-pressure. The block sits between operand sources and result consumers wherever a wide add would otherwise limit clock frequency. It reports carry-out and signed overflow alongside the sum.

---
 rtl/pipelined_adder_pkg.sv | 9 +
 rtl/adder_slice.sv | 19 +
 rtl/pipelined_adder.sv | 80 ++++++++
 tb/tb_pipelined_adder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: shared slice sizing and configuration check for the pipelined adder
package pipelined_adder_pkg;
  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction
  function automatic bit cfg_ok(input int width, input int stages);
    return stages >= 1 && width >= stages && width % stages == 0;
  endfunction
endpackage

// File: rtl/adder_slice.sv
// adder_slice: combinational SW-bit adder returning sum, carry-out and carry into its MSB
module adder_slice #(
  parameter int SW = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          co,
  output logic          cm
);
  logic [SW:0] full;
  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, ci};
    s = full[SW-1:0];
    co = full[SW];
    cm = full[SW-1] ^ a[SW-1] ^ b[SW-1];
  end
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: add/subtract with the carry chain cut into STAGES registered slices
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STAGES = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             SUB,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             OVF,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);
  localparam int SW = slice_width(WIDTH, STAGES);
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
    logic             carry;
    logic             msb_cin;
  } stage_t;
  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a positive multiple of STAGES");
  end
  logic   en;
  stage_t in_st;
  stage_t st_d [STAGES];
  stage_t st_q [STAGES];
  always_comb begin
    in_st = '{valid: IN_VALID, sum: '0, a_rem: A, b_rem: SUB ? ~B : B,
              carry: SUB | CIN, msb_cin: 1'b0};
  end
  // Operands shift down one slice per stage so every stage adds bits [SW-1:0];
  // finished slices enter the sum from the top and land in place after STAGES shifts.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t              prev;
    logic [SW-1:0]       s;
    logic                co;
    logic                cm;
    logic [WIDTH+SW-1:0] sum_cat;
    if (k == 0) begin : g_head
      assign prev = in_st;
    end else begin : g_tail
      assign prev = st_q[k-1];
    end
    adder_slice #(.SW(SW)) u_slice (
      .a (prev.a_rem[SW-1:0]),
      .b (prev.b_rem[SW-1:0]),
      .ci(prev.carry),
      .s (s),
      .co(co),
      .cm(cm)
    );
    assign sum_cat = {s, prev.sum};
    assign st_d[k] = '{valid: prev.valid, sum: sum_cat[WIDTH+SW-1:SW],
                       a_rem: prev.a_rem >> SW, b_rem: prev.b_rem >> SW,
                       carry: co, msb_cin: cm};
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) st_q <= '{default: '0};
    else if (en) st_q <= st_d;
  end
  always_comb begin
    en = !st_q[STAGES-1].valid || OUT_READY;
    IN_READY = en;
    S = st_q[STAGES-1].sum;
    COUT = st_q[STAGES-1].carry;
    OVF = st_q[STAGES-1].msb_cin ^ st_q[STAGES-1].carry;
    OUT_VALID = st_q[STAGES-1].valid;
  end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: table vectors, corner sequences and a scoreboarded random stream
module tb_pipelined_adder;
  localparam int W = 16;
  logic clk = 0, rst = 1;
  logic [W-1:0] a = '0, b = '0, s;
  logic cin = 0, sub = 0, in_valid = 0, in_ready, cout, ovf, out_valid, out_ready = 1;
  logic [3:0] sa = '0, sb = '0, ss;
  logic scin = 0, s_iv = 0, s_ir, scout, sovf, s_ov;
  int errors = 0, checks = 0, popped = 0;
  logic [W+1:0] q[$];

  typedef struct {
    logic [W-1:0] a, b;
    logic cin, sub;
    logic [W-1:0] s;
    logic cout, ovf;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .STAGES(4)) dut (
    .CLK(clk), .RST(rst), .A(a), .B(b), .CIN(cin), .SUB(sub),
    .IN_VALID(in_valid), .IN_READY(in_ready), .S(s), .COUT(cout), .OVF(ovf),
    .OUT_VALID(out_valid), .OUT_READY(out_ready));

  pipelined_adder #(.WIDTH(4), .STAGES(1)) dut_small (
    .CLK(clk), .RST(rst), .A(sa), .B(sb), .CIN(scin), .SUB(1'b0),
    .IN_VALID(s_iv), .IN_READY(s_ir), .S(ss), .COUT(scout), .OVF(sovf),
    .OUT_VALID(s_ov), .OUT_READY(1'b1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Overflow uses the signed-operand rule, independent of the carry-into-MSB form
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic sb_m);
    logic [W-1:0] be;
    logic [W:0] f;
    logic v;
    be = sb_m ? ~y : y;
    f = {1'b0, x} + {1'b0, be} + {{W{1'b0}}, sb_m | c};
    v = (x[W-1] == be[W-1]) && (f[W-1] != x[W-1]);
    return {v, f[W], f[W-1:0]};
  endfunction

  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got %0h expected no output", {ovf, cout, s});
        end else begin
          chk("sb_result", {14'd0, ovf, cout, s}, {14'd0, q.pop_front()});
          popped++;
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                       input logic sb_d, input logic v);
    a = x; b = y; cin = c; sub = sb_d; in_valid = v;
  endtask

  task automatic one_shot(input string name, input vec_t v);
    int lat;
    out_ready = 1;
    drive(v.a, v.b, v.cin, v.sub, 1);
    tick();
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk({name, "_latency"}, lat, 4);
    chk({name, "_s"}, s, v.s);
    chk({name, "_cout"}, cout, v.cout);
    chk({name, "_ovf"}, ovf, v.ovf);
    tick();
  endtask

  initial begin
    int idx, p0, cnt;
    logic acc;
    logic [W-1:0] held;
    tbl[0] = '{16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0};
    tbl[1] = '{16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1};
    tbl[2] = '{16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0};
    tbl[3] = '{16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1};
    tbl[4] = '{16'h1234, 16'h4321, 1, 0, 16'h5556, 0, 0};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 1, 0, 16'hFFFF, 1, 0};
    tbl[6] = '{16'h0000, 16'h0000, 0, 1, 16'h0000, 1, 0};

    tick();
    tick();
    chk("rst_s", s, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 0;
    tick();

    sa = 4; sb = 2; scin = 0; s_iv = 1;
    tick();
    chk("small_valid", s_ov, 1);
    chk("small_s0", ss, 6);
    chk("small_cout0", scout, 0);
    sa = 9; sb = 7; scin = 1;
    tick();
    s_iv = 0;
    chk("small_s1", ss, 1);
    chk("small_cout1", scout, 1);
    chk("small_ovf1", sovf, 0);

    foreach (tbl[i]) one_shot($sformatf("vec%0d", i), tbl[i]);

    p0 = popped;
    idx = 0;
    held = '0;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 5 && c <= 7);
      if (idx < 8) drive(16'(idx * 4099 + 16'h0F0F), 16'(idx * 771 + 3), idx[0], idx[1], 1);
      else in_valid = 0;
      @(negedge clk);
      if (c == 5) held = s;
      if (c >= 5 && c <= 7) chk("bp_in_ready", in_ready, 0);
      if (c >= 6 && c <= 7) begin
        chk("bp_hold_s", s, held);
        chk("bp_hold_valid", out_valid, 1);
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    chk("bp_accepted", idx, 8);
    chk("bp_emitted", popped - p0, 8);
    chk("bp_queue_empty", q.size(), 0);

    for (int i = 0; i < 3; i++) begin
      drive(16'hA5A5 + 16'(i), 16'h1111, 0, 0, 1);
      tick();
    end
    in_valid = 0;
    rst = 1;
    #1;
    chk("mid_rst_s", s, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    tick();
    rst = 0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) cnt++;
    end
    chk("mid_rst_no_stale", cnt, 0);
    one_shot("post_rst", tbl[4]);

    for (int i = 0; i < 10000; i++) begin
      out_ready = ($urandom_range(3) != 0);
      drive(16'($urandom()), 16'($urandom()), 1'($urandom()), 1'($urandom()),
            $urandom_range(4) != 0);
      tick();
    end
    in_valid = 0;
    out_ready = 1;
    cnt = 0;
    while (q.size() != 0 && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("rand_drained", q.size(), 0);
    chk("rand_some_results", popped > 5000, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
